instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/decode/dispatch to ALU, load, store and branch sub-FSMs, then retire.
// Latency: 5 cycles minimum per instruction (NOP 4); a stalled sub-FSM is waited on for TIMEOUT EXEC cycles.
module instr_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  pcOut,
    output logic        memRdEN,
    input  logic [15:0] memData,
    output logic [15:0] irOut,
    output logic        aluStart,
    output logic        ldStart,
    output logic        stStart,
    output logic        brStart,
    input  logic        aluDone,
    input  logic        ldDone,
    input  logic        stDone,
    input  logic        brDone,
    input  logic        brTaken,
    input  logic [7:0]  brTarget,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic        fault,
    output logic [15:0] instrCount
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0010;
    localparam logic [3:0] OP_BR   = 4'b0011;
    localparam logic [3:0] OP_ALU  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          brTakenQ;
    logic [7:0]    brTargetQ;
    logic          matchDone;
    logic [3:0]    nextOp;

    assign nextOp = memData[15:12];

    // Only the done belonging to the instruction held in irOut can complete it.
    always_comb begin
        matchDone = 1'b0;
        case (irOut[15:12])
            OP_ALU:  matchDone = aluDone;
            OP_LD:   matchDone = ldDone;
            OP_ST:   matchDone = stDone;
            OP_BR:   matchDone = brDone;
            default: matchDone = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pcOut      <= 8'h00;
            irOut      <= 16'h0000;
            instrCount <= 16'h0000;
            memRdEN    <= 1'b0;
            aluStart   <= 1'b0;
            ldStart    <= 1'b0;
            stStart    <= 1'b0;
            brStart    <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            fault      <= 1'b0;
            tcnt       <= '0;
            brTakenQ   <= 1'b0;
            brTargetQ  <= 8'h00;
        end else begin
            memRdEN  <= 1'b0;
            aluStart <= 1'b0;
            ldStart  <= 1'b0;
            stStart  <= 1'b0;
            brStart  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        memRdEN <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Starts are registered, so they are decoded from memData here to land in DECODE.
                    irOut    <= memData;
                    state    <= S_DECODE;
                    aluStart <= (nextOp == OP_ALU);
                    ldStart  <= (nextOp == OP_LD);
                    stStart  <= (nextOp == OP_ST);
                    brStart  <= (nextOp == OP_BR);
                end
                S_DECODE: begin
                    brTakenQ <= 1'b0;
                    case (irOut[15:12])
                        OP_ALU, OP_LD, OP_ST, OP_BR: begin
                            state <= S_EXEC;
                            tcnt  <= '0;
                        end
                        OP_NOP: begin
                            state <= S_RETIRE;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                            busy   <= 1'b0;
                        end
                        default: begin
                            state   <= S_HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            busy    <= 1'b0;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (matchDone) begin
                        state <= S_RETIRE;
                        if (irOut[15:12] == OP_BR) begin
                            brTakenQ  <= brTaken;
                            brTargetQ <= brTarget;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        fault  <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RETIRE: begin
                    pcOut <= brTakenQ ? brTargetQ : pcOut + 8'd1;
                    if (instrCount != 16'hFFFF) begin
                        instrCount <= instrCount + 16'd1;
                    end
                    if (run) begin
                        state   <= S_FETCH;
                        memRdEN <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program table, mid-EXEC reset sequence, then randomized instructions.
module tb_instr_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [7:0]  pcOut;
    logic        memRdEN;
    logic [15:0] memData;
    logic [15:0] irOut;
    logic        aluStart, ldStart, stStart, brStart;
    logic        aluDone, ldDone, stDone, brDone;
    logic        brTaken;
    logic [7:0]  brTarget;
    logic        busy, halted, illegal, fault;
    logic [15:0] instrCount;

    instr_sequencer #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .run(run), .pcOut(pcOut), .memRdEN(memRdEN), .memData(memData),
        .irOut(irOut), .aluStart(aluStart), .ldStart(ldStart), .stStart(stStart), .brStart(brStart),
        .aluDone(aluDone), .ldDone(ldDone), .stDone(stDone), .brDone(brDone),
        .brTaken(brTaken), .brTarget(brTarget), .busy(busy), .halted(halted),
        .illegal(illegal), .fault(fault), .instrCount(instrCount)
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          excl_bad = 0;
    logic [15:0] mem [256];
    logic [7:0]  mpc;
    logic [15:0] mcnt;
    bit          pend;
    logic [7:0]  paddr;

    typedef struct {
        bit          rst_b;
        logic [15:0] word;
        int          lat;
        bit          tk;
        logic [7:0]  tgt;
        bit          spur;
        bit          drop;
        int          exp_end;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t tbl[16];

    // Program memory: data is valid only in the cycle after a read strobe, garbage otherwise.
    initial begin
        pend = 1'b0;
        memData = 16'h0000;
        forever begin
            @(negedge clk);
            if (pend) memData = mem[paddr];
            else      memData = 16'($urandom);
            pend  = memRdEN;
            paddr = pcOut;
        end
    end

    initial forever begin
        @(negedge clk);
        if ($countones({memRdEN, aluStart, ldStart, stStart, brStart}) > 1) excl_bad++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [3:0] op);
        case (op)
            4'h8:    return 0;
            4'h1:    return 1;
            4'h2:    return 2;
            4'h3:    return 3;
            4'h0:    return 4;
            4'hF:    return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int end_of(input int k, input int lat);
        if (k < 4) return (lat >= 1 && lat <= T) ? 5 + lat : 4 + T;
        return (k == 4) ? 5 : 4;
    endfunction

    function automatic logic [63:0] rvec();
        return {pcOut, irOut, instrCount, memRdEN, aluStart, ldStart, stStart, brStart,
                busy, halted, illegal, fault};
    endfunction

    task automatic clear_dones();
        aluDone = 1'b0; ldDone = 1'b0; stDone = 1'b0; brDone = 1'b0;
    endtask

    task automatic drive_other(input int k);
        int j;
        j = $urandom_range(0, 3);
        if (j != k) begin
            case (j)
                0:       aluDone = 1'b1;
                1:       ldDone = 1'b1;
                2:       stDone = 1'b1;
                default: brDone = 1'b1;
            endcase
        end
    endtask

    task automatic reset_dut(input bit chk);
        rst = 1'b1;
        run = 1'b0;
        clear_dones();
        repeat (2) @(negedge clk);
        if (chk) check("reset", rvec(), 64'h0);
        rst = 1'b0;
        mpc = 8'h00;
        mcnt = 16'h0000;
    endtask

    // Runs one instruction from its FETCH; ends at the negedge of next FETCH, IDLE or HALT.
    task automatic do_instr(input logic [15:0] word, input int lat, input bit tk, input logic [7:0] tgt,
                            input bit spur, input bit drop, input int exp_end, input logic [7:0] exp_pc);
        int c, n, k, stc, sk, ns, irbad;
        bit ended, hexp, tmo;
        k = kind_of(word[15:12]);
        tmo = (k < 4) && !(lat >= 1 && lat <= T);
        hexp = (k >= 5) || tmo;
        mem[mpc] = word;
        run = 1'b1;
        n = 0;
        while (!memRdEN && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fetch", {memRdEN, pcOut, instrCount}, {1'b1, mpc, mcnt});
        if (!memRdEN) return;
        c = 1; stc = 0; sk = -1; ns = 0; irbad = 0; ended = 1'b0;
        while (!ended && c < 60) begin
            clear_dones();
            brTaken = 1'($urandom);
            brTarget = 8'($urandom);
            if (stc > 0) begin
                if (c - stc == lat) begin
                    case (k)
                        0:       aluDone = 1'b1;
                        1:       ldDone = 1'b1;
                        2:       stDone = 1'b1;
                        default: begin brDone = 1'b1; brTaken = tk; brTarget = tgt; end
                    endcase
                end else if ($urandom_range(0, 3) == 0) begin
                    drive_other(k);
                end
                if (spur && c == stc) stDone = 1'b1;
                if (drop && c == stc + 1) run = 1'b0;
            end
            @(negedge clk);
            c++;
            if (aluStart || ldStart || stStart || brStart) begin
                ns++;
                stc = c;
                sk = aluStart ? 0 : ldStart ? 1 : stStart ? 2 : 3;
            end
            if (c >= 3 && irOut !== word) irbad++;
            ended = memRdEN || halted || !busy;
        end
        clear_dones();
        if (k < 4) check("start", {8'(ns), 8'(sk), 8'(stc)}, {8'd1, 8'(k), 8'd3});
        else       check("start", {8'(ns), 8'(sk), 8'(stc)}, {8'd0, 8'hFF, 8'd0});
        check("length", 64'(c), 64'(exp_end));
        check("ir_stable", 64'(irbad), 64'h0);
        if (hexp) begin
            check("halt", {halted, busy, illegal, fault, pcOut, instrCount},
                  {1'b1, 1'b0, k == 6, tmo, exp_pc, mcnt});
            for (int i = 0; i < 4; i++) begin
                run = ~run;
                aluDone = 1'($urandom); ldDone = 1'($urandom);
                stDone = 1'($urandom); brDone = 1'($urandom);
                @(negedge clk);
            end
            clear_dones();
            check("absorb", {halted, busy, memRdEN, illegal, fault, pcOut, instrCount},
                  {1'b1, 1'b0, 1'b0, k == 6, tmo, exp_pc, mcnt});
        end else begin
            mpc = exp_pc;
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            check("retire", {memRdEN, busy, halted, pcOut, instrCount}, {!drop, !drop, 1'b0, mpc, mcnt});
            if (drop) begin
                repeat (3) @(negedge clk);
                check("idle_hold", {memRdEN, busy, pcOut}, {1'b0, 1'b0, mpc});
            end
        end
    endtask

    initial begin
        int k, lat, r, n, ee;
        bit tk, spur, drop, hexp;
        logic [3:0] op;
        logic [7:0] tgt, epc;
        logic [15:0] w;

        rst = 1'b1; run = 1'b0; brTaken = 1'b0; brTarget = 8'h00;
        clear_dones();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mpc = 8'h00; mcnt = 16'h0000;

        //           rst   word     lat tk    tgt    spur  drop end pc
        tbl[0]  = '{1'b1, 16'h8042, 1,  1'b0, 8'h00, 1'b0, 1'b0, 6,  8'h01};
        tbl[1]  = '{1'b0, 16'h0000, 1,  1'b0, 8'h00, 1'b0, 1'b0, 5,  8'h02};
        tbl[2]  = '{1'b0, 16'h1000, 0,  1'b0, 8'h00, 1'b0, 1'b0, 20, 8'h02};
        tbl[3]  = '{1'b1, 16'h2000, 3,  1'b0, 8'h00, 1'b1, 1'b0, 8,  8'h01};
        tbl[4]  = '{1'b0, 16'h1000, 16, 1'b0, 8'h00, 1'b0, 1'b0, 21, 8'h02};
        tbl[5]  = '{1'b0, 16'h3000, 2,  1'b1, 8'h05, 1'b0, 1'b0, 7,  8'h05};
        tbl[6]  = '{1'b0, 16'h3000, 1,  1'b1, 8'h20, 1'b0, 1'b0, 6,  8'h20};
        tbl[7]  = '{1'b0, 16'h3000, 1,  1'b1, 8'h05, 1'b0, 1'b0, 6,  8'h05};
        tbl[8]  = '{1'b0, 16'h3000, 3,  1'b0, 8'h20, 1'b0, 1'b0, 8,  8'h06};
        tbl[9]  = '{1'b0, 16'h8123, 2,  1'b0, 8'h00, 1'b0, 1'b1, 7,  8'h07};
        tbl[10] = '{1'b0, 16'h3000, 1,  1'b1, 8'hFF, 1'b0, 1'b0, 6,  8'hFF};
        tbl[11] = '{1'b0, 16'h0ABC, 1,  1'b0, 8'h00, 1'b0, 1'b0, 5,  8'h00};
        tbl[12] = '{1'b0, 16'h5000, 1,  1'b0, 8'h00, 1'b0, 1'b0, 4,  8'h00};
        tbl[13] = '{1'b1, 16'hF000, 1,  1'b0, 8'h00, 1'b0, 1'b0, 4,  8'h00};
        tbl[14] = '{1'b1, 16'h2000, 1,  1'b0, 8'h00, 1'b1, 1'b0, 6,  8'h01};
        tbl[15] = '{1'b0, 16'h9000, 1,  1'b0, 8'h00, 1'b0, 1'b0, 4,  8'h01};

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_b) reset_dut(i == 0);
            do_instr(tbl[i].word, tbl[i].lat, tbl[i].tk, tbl[i].tgt, tbl[i].spur, tbl[i].drop,
                     tbl[i].exp_end, tbl[i].exp_pc);
        end

        // Reset in the first EXEC cycle, coincident with run and the matching done.
        reset_dut(1'b0);
        do_instr(16'h0000, 1, 1'b0, 8'h00, 1'b0, 1'b0, 5, 8'h01);
        mem[1] = 16'h8000;
        run = 1'b1;
        n = 0;
        while (!aluStart && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_exec_start", {aluStart, pcOut, irOut}, {1'b1, 8'h01, 16'h8000});
        @(negedge clk);
        rst = 1'b1; aluDone = 1'b1; run = 1'b1;
        @(negedge clk);
        check("mid_exec_reset", rvec(), 64'h0);
        rst = 1'b0; run = 1'b0; aluDone = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {busy, memRdEN, halted, pcOut, instrCount}, 64'h0);
        mpc = 8'h00; mcnt = 16'h0000;

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            lat = $urandom_range(1, T);
            tk = 1'($urandom);
            tgt = 8'($urandom);
            spur = ($urandom_range(0, 3) == 0);
            if (r < 18) begin
                k = r % 5;
            end else if (r == 18) begin
                n = $urandom_range(0, 10);
                k = (n == 10) ? 5 : 6;
            end else begin
                k = $urandom_range(0, 3);
                lat = 0;
            end
            case (k)
                0: op = 4'h8;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'h3;
                4: op = 4'h0;
                5: op = 4'hF;
                default: op = (n < 4) ? 4'(4 + n) : 4'(5 + n);
            endcase
            w = {op, 12'($urandom)};
            drop = (k < 4) && (lat != 0) && ($urandom_range(0, 7) == 0);
            hexp = (k >= 5) || (lat == 0);
            ee = end_of(k, lat);
            epc = hexp ? mpc : ((k == 3 && tk) ? tgt : 8'(mpc + 8'd1));
            do_instr(w, lat, tk, tgt, spur, drop, ee, epc);
            if (hexp) reset_dut(1'b0);
        end

        check("exclusive_strobes", 64'(excl_bad), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
